// File: rtl/reorder_buffer.sv
// reorder_buffer
// Circular in-order reorder buffer for the Tomasulo core. Entries are
// allocated at the tail by the Dispatcher, completed by CDB broadcasts and
// retired from the head in program order through the RegisterFile commit
// interface. A branch whose resolved direction differs from its prediction
// flushes every entry at its commit edge and redirects fetch.
//
// Ports:
//   Sys_clk, Sys_rst, Sys_rdy    clock, synchronous active-high reset, global stall (low = hold)
//   DPRoB_*                      allocation request and operand tag lookups from the Dispatcher
//   RoBDP_full, RoBDP_index      no free entry / index of the next allocation
//   RoBDP_Q*_ready, RoBDP_V*     lookup results (CDB bypass has priority)
//   CDBRoB_*                     result broadcast (value and actual branch direction)
//   RoBRF_*                      head commit to the RegisterFile
//   RoBIF_jump_en, RoBIF_next_pc fetch redirect on a committed misprediction
module reorder_buffer #(
  parameter int RoB_WIDTH = 8,
  parameter int EX_RoB_WIDTH = 9,
  parameter int EX_REG_WIDTH = 6,
  parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = 9'b100000000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    DPRoB_en,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_ready,
  input  logic [31:0]             DPRoB_value,
  input  logic                    DPRoB_is_branch,
  input  logic                    DPRoB_pred_taken,
  input  logic [31:0]             DPRoB_alt_pc,
  input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qj,
  input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qk,
  output logic                    RoBDP_full,
  output logic [RoB_WIDTH-1:0]    RoBDP_index,
  output logic                    RoBDP_Qj_ready,
  output logic                    RoBDP_Qk_ready,
  output logic [31:0]             RoBDP_Vj,
  output logic [31:0]             RoBDP_Vk,
  input  logic                    CDBRoB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRoB_index,
  input  logic [31:0]             CDBRoB_value,
  input  logic                    CDBRoB_taken,
  output logic                    RoBRF_en,
  output logic                    RoBRF_pre_judge,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBIF_jump_en,
  output logic [31:0]             RoBIF_next_pc
);

  localparam int RoB_SIZE = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH-1:0] PTR_ZERO = {RoB_WIDTH{1'b0}};
  localparam logic [RoB_WIDTH-1:0] PTR_ONE  = {{(RoB_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RoB_WIDTH:0]   CNT_ZERO = {(RoB_WIDTH+1){1'b0}};
  localparam logic [RoB_WIDTH:0]   CNT_ONE  = {{RoB_WIDTH{1'b0}}, 1'b1};
  localparam logic [RoB_WIDTH:0]   CNT_FULL = {1'b1, {RoB_WIDTH{1'b0}}};

  // Control state (reset)
  logic [RoB_SIZE-1:0]     busy_r;
  logic [RoB_SIZE-1:0]     ready_r;
  logic [RoB_WIDTH-1:0]    head_r;
  logic [RoB_WIDTH-1:0]    tail_r;
  logic [RoB_WIDTH:0]      count_r;

  // Entry payload (not reset: only read while the entry is live, or gated by count)
  logic [EX_REG_WIDTH-1:0] rd_r       [RoB_SIZE];
  logic [31:0]             value_r    [RoB_SIZE];
  logic [31:0]             alt_pc_r   [RoB_SIZE];
  logic [RoB_SIZE-1:0]     is_branch_r;
  logic [RoB_SIZE-1:0]     pred_taken_r;
  logic [RoB_SIZE-1:0]     taken_r;

  logic has_head_s;
  logic full_s;
  logic commit_s;
  logic mispredict_s;
  logic alloc_s;
  logic wb_s;

  // Operand lookup: a CDB broadcast this cycle wins over the stored entry;
  // an incomplete entry reports value 0.
  function automatic logic [32:0] lookup(input logic [EX_RoB_WIDTH-1:0] tag_s);
    logic [RoB_WIDTH-1:0] idx_s;
    idx_s = tag_s[RoB_WIDTH-1:0];
    if (tag_s == NON_DEP) begin
      lookup = {1'b0, 32'h0000_0000};
    end else if (CDBRoB_en && (CDBRoB_index == idx_s)) begin
      lookup = {1'b1, CDBRoB_value};
    end else if (ready_r[idx_s]) begin
      lookup = {1'b1, value_r[idx_s]};
    end else begin
      lookup = {1'b0, 32'h0000_0000};
    end
  endfunction

  assign has_head_s = (count_r != CNT_ZERO);
  assign full_s     = (count_r == CNT_FULL);

  // Per-cycle actions; everything is suppressed while Sys_rdy is low.
  // A committing misprediction discards same-cycle allocation and write-back.
  always_comb begin
    commit_s     = 1'b0;
    mispredict_s = 1'b0;
    alloc_s      = 1'b0;
    wb_s         = 1'b0;
    if (Sys_rdy) begin
      commit_s     = has_head_s && ready_r[head_r];
      mispredict_s = commit_s && is_branch_r[head_r] &&
                     (taken_r[head_r] != pred_taken_r[head_r]);
      alloc_s      = DPRoB_en && !full_s && !mispredict_s;
      wb_s         = CDBRoB_en && busy_r[CDBRoB_index] && !mispredict_s;
    end else begin
      commit_s     = 1'b0;
      mispredict_s = 1'b0;
      alloc_s      = 1'b0;
      wb_s         = 1'b0;
    end
  end

  // Commit, redirect and lookup outputs, combinational from registered state.
  always_comb begin
    RoBDP_full      = full_s;
    RoBDP_index     = tail_r;
    RoBRF_en        = commit_s;
    RoBRF_pre_judge = !mispredict_s;
    RoBIF_jump_en   = mispredict_s;
    RoBRF_RoB_index = head_r;
    RoBRF_rd        = {EX_REG_WIDTH{1'b0}};
    RoBRF_value     = 32'h0000_0000;
    RoBIF_next_pc   = 32'h0000_0000;
    if (has_head_s) begin
      RoBRF_rd      = rd_r[head_r];
      RoBRF_value   = value_r[head_r];
      RoBIF_next_pc = alt_pc_r[head_r];
    end else begin
      RoBRF_rd      = {EX_REG_WIDTH{1'b0}};
      RoBRF_value   = 32'h0000_0000;
      RoBIF_next_pc = 32'h0000_0000;
    end
    {RoBDP_Qj_ready, RoBDP_Vj} = lookup(DPRoB_Qj);
    {RoBDP_Qk_ready, RoBDP_Vk} = lookup(DPRoB_Qk);
  end

  // Pointers, occupancy and per-entry busy/ready flags.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      busy_r  <= {RoB_SIZE{1'b0}};
      ready_r <= {RoB_SIZE{1'b0}};
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (mispredict_s) begin
      busy_r  <= {RoB_SIZE{1'b0}};
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (alloc_s) begin
        busy_r[tail_r]  <= 1'b1;
        ready_r[tail_r] <= DPRoB_ready;
        tail_r          <= tail_r + PTR_ONE;
      end
      if (wb_s) begin
        ready_r[CDBRoB_index] <= 1'b1;
      end
      // Head and tail coincide only when empty (no commit) or full (no
      // allocation), so this clear never collides with the allocation above.
      if (commit_s) begin
        busy_r[head_r] <= 1'b0;
        head_r         <= head_r + PTR_ONE;
      end
      case ({alloc_s, commit_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload capture at allocation and at CDB write-back.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      if (alloc_s) begin
        rd_r[tail_r]         <= DPRoB_rd;
        value_r[tail_r]      <= DPRoB_value;
        alt_pc_r[tail_r]     <= DPRoB_alt_pc;
        is_branch_r[tail_r]  <= DPRoB_is_branch;
        pred_taken_r[tail_r] <= DPRoB_pred_taken;
        // Until resolved, the outcome is assumed to match the prediction.
        taken_r[tail_r]      <= DPRoB_pred_taken;
      end
      if (wb_s) begin
        value_r[CDBRoB_index] <= CDBRoB_value;
        taken_r[CDBRoB_index] <= CDBRoB_taken;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  localparam int SZ = 8;
  localparam logic [3:0] NDEP = 4'b1000;
  localparam logic [5:0] NREG = 6'b100000;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst, Sys_rdy;
  logic        DPRoB_en, DPRoB_ready, DPRoB_is_branch, DPRoB_pred_taken;
  logic [5:0]  DPRoB_rd;
  logic [31:0] DPRoB_value, DPRoB_alt_pc;
  logic [3:0]  DPRoB_Qj, DPRoB_Qk;
  logic        RoBDP_full, RoBDP_Qj_ready, RoBDP_Qk_ready;
  logic [2:0]  RoBDP_index;
  logic [31:0] RoBDP_Vj, RoBDP_Vk;
  logic        CDBRoB_en, CDBRoB_taken;
  logic [2:0]  CDBRoB_index;
  logic [31:0] CDBRoB_value;
  logic        RoBRF_en, RoBRF_pre_judge, RoBIF_jump_en;
  logic [2:0]  RoBRF_RoB_index;
  logic [5:0]  RoBRF_rd;
  logic [31:0] RoBRF_value, RoBIF_next_pc;

  int total = 0;
  int bad = 0;

  // Reference model: live entries in program order.
  typedef struct {
    logic [5:0]  rd;
    logic [31:0] val;
    bit          rdy;
    bit          br;
    bit          pred;
    bit          tk;
    logic [31:0] alt;
    int          idx;
  } ent_t;
  ent_t q[$];
  int next_idx = 0;

  always #5 Sys_clk = ~Sys_clk;

  reorder_buffer #(
    .RoB_WIDTH(3), .EX_RoB_WIDTH(4), .EX_REG_WIDTH(6), .NON_DEP(4'b1000)
  ) dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .DPRoB_en(DPRoB_en), .DPRoB_rd(DPRoB_rd), .DPRoB_ready(DPRoB_ready),
    .DPRoB_value(DPRoB_value), .DPRoB_is_branch(DPRoB_is_branch),
    .DPRoB_pred_taken(DPRoB_pred_taken), .DPRoB_alt_pc(DPRoB_alt_pc),
    .DPRoB_Qj(DPRoB_Qj), .DPRoB_Qk(DPRoB_Qk),
    .RoBDP_full(RoBDP_full), .RoBDP_index(RoBDP_index),
    .RoBDP_Qj_ready(RoBDP_Qj_ready), .RoBDP_Qk_ready(RoBDP_Qk_ready),
    .RoBDP_Vj(RoBDP_Vj), .RoBDP_Vk(RoBDP_Vk),
    .CDBRoB_en(CDBRoB_en), .CDBRoB_index(CDBRoB_index),
    .CDBRoB_value(CDBRoB_value), .CDBRoB_taken(CDBRoB_taken),
    .RoBRF_en(RoBRF_en), .RoBRF_pre_judge(RoBRF_pre_judge),
    .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd),
    .RoBRF_value(RoBRF_value), .RoBIF_jump_en(RoBIF_jump_en),
    .RoBIF_next_pc(RoBIF_next_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    DPRoB_en = 1'b0; DPRoB_rd = 6'd0; DPRoB_ready = 1'b0; DPRoB_value = 32'd0;
    DPRoB_is_branch = 1'b0; DPRoB_pred_taken = 1'b0; DPRoB_alt_pc = 32'd0;
    DPRoB_Qj = NDEP; DPRoB_Qk = NDEP;
    CDBRoB_en = 1'b0; CDBRoB_index = 3'd0; CDBRoB_value = 32'd0; CDBRoB_taken = 1'b0;
  endtask

  task automatic alloc(input logic [5:0] rd, input bit rdy, input logic [31:0] val,
                       input bit br, input bit pred, input logic [31:0] alt);
    DPRoB_en = 1'b1; DPRoB_rd = rd; DPRoB_ready = rdy; DPRoB_value = val;
    DPRoB_is_branch = br; DPRoB_pred_taken = pred; DPRoB_alt_pc = alt;
  endtask

  task automatic cdb(input logic [2:0] idx, input logic [31:0] val, input bit tk);
    CDBRoB_en = 1'b1; CDBRoB_index = idx; CDBRoB_value = val; CDBRoB_taken = tk;
  endtask

  task automatic chk_lookup(input string tag, input logic [3:0] t, input logic obs_r,
                            input logic [31:0] obs_v);
    bit known = 0;
    logic er = 1'b0;
    logic [31:0] ev = 32'd0;
    if (t == NDEP) known = 1;
    else if (CDBRoB_en && (CDBRoB_index == t[2:0])) begin
      known = 1; er = 1'b1; ev = CDBRoB_value;
    end else begin
      foreach (q[k]) if (q[k].idx == int'(t[2:0])) begin
        known = 1; er = q[k].rdy; ev = q[k].rdy ? q[k].val : 32'd0;
      end
    end
    if (known) begin
      chk({tag, "_ready"}, {31'd0, obs_r}, {31'd0, er});
      chk({tag, "_value"}, obs_v, ev);
    end
  endtask

  // Compare every output against the model, #1 after inputs change at negedge.
  task automatic settle();
    bit ne, en_e, mis_e;
    #1;
    ne = (q.size() > 0);
    en_e = 0; mis_e = 0;
    if (ne) begin
      en_e  = Sys_rdy && q[0].rdy;
      mis_e = en_e && q[0].br && (q[0].tk != q[0].pred);
    end
    chk("full", {31'd0, RoBDP_full}, {31'd0, q.size() == SZ});
    chk("alloc_index", {29'd0, RoBDP_index}, 32'(next_idx));
    chk("rf_en", {31'd0, RoBRF_en}, {31'd0, en_e});
    chk("pre_judge", {31'd0, RoBRF_pre_judge}, {31'd0, !mis_e});
    chk("jump_en", {31'd0, RoBIF_jump_en}, {31'd0, mis_e});
    chk("rf_rob_index", {29'd0, RoBRF_RoB_index}, 32'((next_idx - q.size() + SZ) % SZ));
    chk("rf_rd", {26'd0, RoBRF_rd}, ne ? {26'd0, q[0].rd} : 32'd0);
    chk("rf_value", RoBRF_value, ne ? q[0].val : 32'd0);
    if (mis_e) chk("next_pc", RoBIF_next_pc, q[0].alt);
    chk_lookup("qj", DPRoB_Qj, RoBDP_Qj_ready, RoBDP_Vj);
    chk_lookup("qk", DPRoB_Qk, RoBDP_Qk_ready, RoBDP_Vk);
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit en, mis, full;
    ent_t e;
    @(posedge Sys_clk);
    if (Sys_rst) begin
      q.delete(); next_idx = 0;
    end else if (Sys_rdy) begin
      en = 0; mis = 0;
      if (q.size() > 0) begin
        en  = q[0].rdy;
        mis = en && q[0].br && (q[0].tk != q[0].pred);
      end
      if (mis) begin
        q.delete(); next_idx = 0;
      end else begin
        if (CDBRoB_en) foreach (q[k]) if (q[k].idx == int'(CDBRoB_index)) begin
          q[k].val = CDBRoB_value; q[k].tk = CDBRoB_taken; q[k].rdy = 1;
        end
        full = (q.size() == SZ);
        if (en) void'(q.pop_front());
        if (DPRoB_en && !full) begin
          e.rd = DPRoB_rd; e.val = DPRoB_value; e.rdy = DPRoB_ready;
          e.br = DPRoB_is_branch; e.pred = DPRoB_pred_taken; e.tk = DPRoB_pred_taken;
          e.alt = DPRoB_alt_pc; e.idx = next_idx;
          q.push_back(e);
          next_idx = (next_idx + 1) % SZ;
        end
      end
    end
    @(negedge Sys_clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    int mode, pct;
    idle(); Sys_rst = 1'b1; Sys_rdy = 1'b1;
    @(negedge Sys_clk);
    tick();
    Sys_rst = 1'b0;

    // Reset state
    settle();
    chk("rst_index", {29'd0, RoBDP_index}, 32'd0);
    chk("rst_full", {31'd0, RoBDP_full}, 32'd0);
    chk("rst_rf_en", {31'd0, RoBRF_en}, 32'd0);
    chk("rst_pre_judge", {31'd0, RoBRF_pre_judge}, 32'd1);
    chk("rst_jump_en", {31'd0, RoBIF_jump_en}, 32'd0);
    tick();

    // In-order commit despite out-of-order completion
    alloc(6'd5, 0, 32'd0, 0, 0, 32'd0); cyc();
    alloc(6'd6, 0, 32'd0, 0, 0, 32'd0); cyc();
    idle(); cdb(3'd1, 32'h22, 0); cyc();
    idle(); cdb(3'd0, 32'h11, 0); settle();
    chk("io_wait_head", {31'd0, RoBRF_en}, 32'd0); tick();
    idle(); settle();
    chk("io_first_en", {31'd0, RoBRF_en}, 32'd1);
    chk("io_first_rd", {26'd0, RoBRF_rd}, 32'd5);
    chk("io_first_val", RoBRF_value, 32'h11);
    chk("io_first_idx", {29'd0, RoBRF_RoB_index}, 32'd0);
    tick(); settle();
    chk("io_second_rd", {26'd0, RoBRF_rd}, 32'd6);
    chk("io_second_val", RoBRF_value, 32'h22);
    chk("io_second_idx", {29'd0, RoBRF_RoB_index}, 32'd1);
    tick();

    // Mispredicted branch at index 2 flushes a younger ready entry
    alloc(NREG, 0, 32'd0, 1, 0, 32'h1000); settle();
    chk("mp_branch_idx", {29'd0, RoBDP_index}, 32'd2); tick();
    alloc(6'd7, 1, 32'h77, 0, 0, 32'd0); cyc();
    idle(); cdb(3'd2, 32'd0, 1); cyc();
    idle(); settle();
    chk("mp_en", {31'd0, RoBRF_en}, 32'd1);
    chk("mp_pre_judge", {31'd0, RoBRF_pre_judge}, 32'd0);
    chk("mp_jump_en", {31'd0, RoBIF_jump_en}, 32'd1);
    chk("mp_next_pc", RoBIF_next_pc, 32'h1000);
    tick(); settle();
    chk("mp_after_en", {31'd0, RoBRF_en}, 32'd0);
    chk("mp_after_index", {29'd0, RoBDP_index}, 32'd0);
    tick(); settle();
    chk("mp_younger_dropped", {31'd0, RoBRF_en}, 32'd0);
    tick();

    // Lookup bypass and NON_DEP
    for (int i = 0; i < 4; i++) begin
      alloc(6'(i + 1), 0, 32'd0, 0, 0, 32'd0); cyc();
    end
    idle(); DPRoB_Qj = 4'd3; DPRoB_Qk = NDEP; cdb(3'd3, 32'hABCD, 0); settle();
    chk("byp_qj_ready", {31'd0, RoBDP_Qj_ready}, 32'd1);
    chk("byp_vj", RoBDP_Vj, 32'hABCD);
    chk("byp_qk_ready", {31'd0, RoBDP_Qk_ready}, 32'd0);
    chk("byp_vk", RoBDP_Vk, 32'd0);
    tick();
    idle(); DPRoB_Qj = 4'd3; DPRoB_Qk = 4'd0; cyc();

    // Reset with live entries and a pending allocation
    idle(); Sys_rst = 1'b1; alloc(6'd9, 1, 32'h9, 0, 0, 32'd0); cyc();
    Sys_rst = 1'b0; idle(); settle();
    chk("mr_en", {31'd0, RoBRF_en}, 32'd0);
    chk("mr_index", {29'd0, RoBDP_index}, 32'd0);
    tick();

    // Full and wrap
    for (int i = 0; i < SZ; i++) begin
      alloc(6'(i + 1), 0, 32'(i), 0, 0, 32'd0); cyc();
    end
    idle(); settle();
    chk("fw_full", {31'd0, RoBDP_full}, 32'd1);
    tick();
    alloc(6'd9, 1, 32'h99, 0, 0, 32'd0); cyc();
    idle(); settle();
    chk("fw_ninth_ignored", {31'd0, RoBDP_full}, 32'd1);
    tick();
    idle(); cdb(3'd0, 32'h5, 0); cyc();
    alloc(6'd10, 1, 32'hA0, 0, 0, 32'd0); settle();
    chk("fw_commit_en", {31'd0, RoBRF_en}, 32'd1);
    chk("fw_full_during_commit", {31'd0, RoBDP_full}, 32'd1);
    tick(); settle();
    chk("fw_full_drop", {31'd0, RoBDP_full}, 32'd0);
    chk("fw_wrap_index", {29'd0, RoBDP_index}, 32'd0);
    tick();
    idle(); settle();
    chk("fw_after_wrap", {29'd0, RoBDP_index}, 32'd1);
    tick();

    // Stall with a ready head
    idle(); cdb(3'd1, 32'h33, 0); cyc();
    idle(); Sys_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_en", {31'd0, RoBRF_en}, 32'd0);
      chk("stall_head", {29'd0, RoBRF_RoB_index}, 32'd1);
      tick();
    end
    Sys_rdy = 1'b1; settle();
    chk("stall_resume_en", {31'd0, RoBRF_en}, 32'd1);
    chk("stall_resume_val", RoBRF_value, 32'h33);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      pct = ((n / 200) % 2 == 1) ? 85 : 40;
      Sys_rst = ($urandom_range(0, 499) == 0);
      Sys_rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < pct) begin
        if ($urandom_range(0, 3) == 0)
          alloc(6'($urandom), 0, $urandom, 1, $urandom_range(0, 1), $urandom);
        else
          alloc(6'($urandom), $urandom_range(0, 2) == 0, $urandom, 0, 0, 32'd0);
      end
      if ($urandom_range(0, 99) < 60) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          cdb(3'(q[$urandom_range(0, q.size() - 1)].idx), $urandom, $urandom_range(0, 1));
        else
          cdb(3'($urandom), $urandom, $urandom_range(0, 1));
      end
      for (int s = 0; s < 2; s++) begin
        logic [3:0] t;
        mode = $urandom_range(0, 3);
        if (mode == 0) t = NDEP;
        else if (mode == 1 && q.size() > 0) t = {1'b0, 3'(q[$urandom_range(0, q.size() - 1)].idx)};
        else if (mode == 2) t = {1'b0, CDBRoB_index};
        else t = 4'($urandom);
        if (s == 0) DPRoB_Qj = t; else DPRoB_Qk = t;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
